// File: rtl/cci_mpf_prim_arb_rr_wgt_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
// The master side owns requests and weights; the slave side (the arbiter) returns grants.
interface cci_mpf_prim_arb_rr_wgt_if #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned WEIGHT_BITS = 4
);
  localparam int unsigned IdxW = $clog2(NUM_CLIENTS);

  logic                               ena;
  logic [NUM_CLIENTS-1:0]             request;
  logic [NUM_CLIENTS-1:0]             request_last;
  logic [NUM_CLIENTS*WEIGHT_BITS-1:0] weight;
  logic [NUM_CLIENTS-1:0]             grant;
  logic [IdxW-1:0]                    grantIdx;
  logic                               locked;

  modport master (
    output ena, request, request_last, weight,
    input  grant, grantIdx, locked
  );

  modport slave (
    input  ena, request, request_last, weight,
    output grant, grantIdx, locked
  );
endinterface

// File: rtl/cci_mpf_prim_arb_rr_wgt.sv
// Round-robin arbiter with per-client weighted quanta and multi-beat packet locking.
// Grant is combinational; priority, ownership, credits and lock are registered.
module cci_mpf_prim_arb_rr_wgt #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned WEIGHT_BITS = 4
) (
  input logic                        clk,
  input logic                        reset,
  cci_mpf_prim_arb_rr_wgt_if.slave   arb
);
  localparam int unsigned IdxW = $clog2(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0]   base_q;
  logic                     owner_valid_q;
  logic [IdxW-1:0]          owner_idx_q;
  logic [WEIGHT_BITS-1:0]   credits_q;
  logic                     lock_q;

  logic [2*NUM_CLIENTS-1:0] req_dbl;
  logic [2*NUM_CLIENTS-1:0] rr_dbl;
  logic [NUM_CLIENTS-1:0]   rr_win;
  logic [NUM_CLIENTS-1:0]   owner_oh;
  logic [NUM_CLIENTS-1:0]   winner;
  logic [IdxW-1:0]          win_idx;
  logic [WEIGHT_BITS-1:0]   weight_w;
  logic                     last_w;
  logic                     new_owner;
  logic                     fire;
  logic [WEIGHT_BITS-1:0]   credits_d;

  // Double-width subtract: the lowest request at or above base wins, wrapping to the low half.
  assign req_dbl = {arb.request, arb.request};
  assign rr_dbl  = req_dbl & ~(req_dbl - {{NUM_CLIENTS{1'b0}}, base_q});
  assign rr_win  = rr_dbl[NUM_CLIENTS-1:0] | rr_dbl[2*NUM_CLIENTS-1:NUM_CLIENTS];

  always_comb begin
    owner_oh = '0;
    owner_oh[owner_idx_q] = 1'b1;
  end

  always_comb begin
    if (lock_q) begin
      // Mid-packet: only the owner may proceed, and nobody else fills its bubbles.
      winner = arb.request[owner_idx_q] ? owner_oh : '0;
    end else if (owner_valid_q && (credits_q != '0) && arb.request[owner_idx_q]) begin
      winner = owner_oh;
    end else begin
      winner = rr_win;
    end
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (winner[i]) win_idx = IdxW'(i);
    end
  end

  assign arb.grant    = reset ? '0 : (winner & {NUM_CLIENTS{arb.ena}});
  assign arb.grantIdx = win_idx;
  assign arb.locked   = lock_q;

  assign weight_w  = arb.weight[int'(win_idx)*WEIGHT_BITS +: WEIGHT_BITS];
  assign last_w    = arb.request_last[win_idx];
  assign new_owner = !owner_valid_q || (win_idx != owner_idx_q);
  assign fire      = arb.ena && (winner != '0);

  always_comb begin
    if (new_owner) begin
      // A zero weight still earns a single grant.
      credits_d = (weight_w == '0) ? '0 : weight_w - WEIGHT_BITS'(1);
    end else begin
      credits_d = (credits_q == '0) ? '0 : credits_q - WEIGHT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q        <= {{(NUM_CLIENTS-1){1'b0}}, 1'b1};
      owner_valid_q <= 1'b0;
      owner_idx_q   <= '0;
      credits_q     <= '0;
      lock_q        <= 1'b0;
    end else if (fire) begin
      base_q        <= {winner[NUM_CLIENTS-2:0], winner[NUM_CLIENTS-1]};
      owner_idx_q   <= win_idx;
      owner_valid_q <= !(last_w && (credits_d == '0));
      credits_q     <= credits_d;
      lock_q        <= !last_w;
    end
  end

endmodule

// File: tb/tb_cci_mpf_prim_arb_rr_wgt.sv
// Directed bench for the weighted round-robin arbiter; stimulus queues expected
// per-cycle outputs and a negedge monitor pops and compares them.
module tb_cci_mpf_prim_arb_rr_wgt;
  logic clk = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [3:0] grant;
    int         idx;     // -1: grantIdx not checked
    logic       locked;
  } exp_t;

  exp_t sb[$];

  cci_mpf_prim_arb_rr_wgt_if #(.NUM_CLIENTS(4), .WEIGHT_BITS(4)) arb_if ();

  cci_mpf_prim_arb_rr_wgt #(.NUM_CLIENTS(4), .WEIGHT_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (arb_if.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ((arb_if.grant !== e.grant) || (arb_if.locked !== e.locked) ||
          ((e.idx >= 0) && (arb_if.grantIdx !== 2'(e.idx)))) begin
        failures++;
        $display("FAIL %s: got grant=%b idx=%0d locked=%b, want grant=%b idx=%0d locked=%b",
                 e.name, arb_if.grant, arb_if.grantIdx, arb_if.locked,
                 e.grant, e.idx, e.locked);
      end
    end
  end

  // One clock of stimulus; optionally queue the outputs expected in that cycle.
  task automatic cyc(input logic [3:0] req, input logic [3:0] last, input logic en,
                     input logic rst, input bit chk, input logic [3:0] eg, input int ei,
                     input logic el, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset               = rst;
    arb_if.ena          = en;
    arb_if.request      = req;
    arb_if.request_last = last;
    if (chk) begin
      e.name   = nm;
      e.grant  = eg;
      e.idx    = ei;
      e.locked = el;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset(input string nm);
    cyc(4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 4'h0, -1, 1'b0, nm);
    cyc(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 4'h0, -1, 1'b0, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] seq1 [5];
    logic [3:0] seq2 [9];
    seq1 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    seq2 = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h1, 4'h1};

    arb_if.ena          = 1'b1;
    arb_if.request      = 4'hF;
    arb_if.request_last = 4'hF;
    arb_if.weight       = 16'h1111;

    // Reset state: grant held low while reset is high.
    do_reset("reset");

    // 1: equal weights rotate 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      cyc(4'hF, 4'hF, 1'b1, 1'b0, 1'b1, seq1[i], (i == 4) ? 0 : i, 1'b0, "rr_equal");
    end

    // 2: client0 weight 3.
    do_reset("reset2");
    arb_if.weight = 16'h1113;
    for (int i = 0; i < 9; i++) begin
      cyc(4'hF, 4'hF, 1'b1, 1'b0, 1'b1, seq2[i], -1, 1'b0, "weighted");
    end

    // 3: 4-beat packet from client1 with client2 also requesting.
    do_reset("reset3");
    arb_if.weight = 16'h1111;
    cyc(4'h6, 4'h4, 1'b1, 1'b0, 1'b1, 4'h2, 1, 1'b0, "pkt_beat1");
    cyc(4'h6, 4'h4, 1'b1, 1'b0, 1'b1, 4'h2, 1, 1'b1, "pkt_beat2");
    cyc(4'h6, 4'h4, 1'b1, 1'b0, 1'b1, 4'h2, 1, 1'b1, "pkt_beat3");
    cyc(4'h6, 4'h6, 1'b1, 1'b0, 1'b1, 4'h2, 1, 1'b1, "pkt_beat4");
    cyc(4'h4, 4'h4, 1'b1, 1'b0, 1'b1, 4'h4, 2, 1'b0, "pkt_after");

    // 4: locked owner drops request; client3 must not be served.
    do_reset("reset4");
    cyc(4'h2, 4'h0, 1'b1, 1'b0, 1'b1, 4'h2, 1, 1'b0, "lock_beat1");
    cyc(4'hA, 4'h0, 1'b1, 1'b0, 1'b1, 4'h2, 1, 1'b1, "lock_beat2");
    cyc(4'h8, 4'h8, 1'b1, 1'b0, 1'b1, 4'h0, -1, 1'b1, "lock_gap1");
    cyc(4'h8, 4'h8, 1'b1, 1'b0, 1'b1, 4'h0, -1, 1'b1, "lock_gap2");
    cyc(4'hA, 4'hA, 1'b1, 1'b0, 1'b1, 4'h2, 1, 1'b1, "lock_resume");
    cyc(4'h8, 4'h8, 1'b1, 1'b0, 1'b1, 4'h8, 3, 1'b0, "lock_release");

    // 5: ena stall holds state; the stalled winner is granted afterwards.
    do_reset("reset5");
    cyc(4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'h1, 0, 1'b0, "stall_pre");
    for (int i = 0; i < 3; i++) begin
      cyc(4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 4'h0, 1, 1'b0, "stall_ena0");
    end
    cyc(4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'h2, 1, 1'b0, "stall_post");
    cyc(4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'h4, 2, 1'b0, "stall_post2");

    // 6: reset mid-lock on client2.
    do_reset("reset6");
    cyc(4'h4, 4'h0, 1'b1, 1'b0, 1'b1, 4'h4, 2, 1'b0, "rstlock_beat1");
    cyc(4'h4, 4'h0, 1'b1, 1'b0, 1'b1, 4'h4, 2, 1'b1, "rstlock_beat2");
    cyc(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 4'h0, -1, 1'b1, "rstlock_inreset");
    cyc(4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'h1, 0, 1'b0, "rstlock_after");
    cyc(4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'h2, 1, 1'b0, "rstlock_after2");

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cci_mpf_prim_arb_rr_wgt.md
Name: cci_mpf_prim_arb_rr_wgt

Overview:
Parametrised successor to the team's single-grant round-robin arbiter. It adds per-client weighted quanta, so a winner may keep the grant for up to weight[i] consecutive grants. It also adds multi-beat packet locking, so a grant is never split mid-packet. It sits in front of shared CCI request channels, such as the VC/write-data muxes, where multi-line writes must stay contiguous and bandwidth shares must be tunable at run time.

Parameters:
NUM_CLIENTS, 4, number of requesters; legal range is 2 or more.
WEIGHT_BITS, 4, width of each per-client weight field.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
ena  input  1  downstream can accept a grant this cycle.
request  input  NUM_CLIENTS  per-client request, one bit per client.
request_last  input  NUM_CLIENTS  qualifies request; 1 means this beat ends the client's packet.
weight  input  NUM_CLIENTS*WEIGHT_BITS  per-client quantum; client i uses bits [i*WEIGHT_BITS +: WEIGHT_BITS]. Sampled only when a new owner is granted.
grant  output  NUM_CLIENTS  one-hot grant, combinational, same cycle as request.
grantIdx  output  $clog2(NUM_CLIENTS)  index of the winner; valid only when grant is nonzero.
locked  output  1  registered; a packet is in progress.

Behaviour:
State:
- base: one-hot priority vector.
- owner_valid and owner_idx: current quantum holder.
- credits: WEIGHT_BITS wide.
- lock: registered; drives the locked output.

Reset values:
- base = 1; owner_valid = 0; credits = 0; lock = 0.
- grant = 0 while reset is high, regardless of request.

Winner selection (combinational):
- Priority 1: if lock=1, only owner_idx is eligible. grant = onehot(owner_idx) if request[owner_idx], else grant = 0 and no other client is served.
- Priority 2: else if owner_valid, credits>0 and request[owner_idx], owner_idx wins.
- Priority 3: otherwise, standard round-robin over request starting at base, using the double-width subtract method.
- grant = winner & {NUM_CLIENTS{ena}}.
- grantIdx is computed even when ena=0; it is meaningless when request=0.

Update on a cycle where ena=1 and any grant is issued to winner w:
- base <= onehot(w) rotated left by 1.
- If w is a new owner (owner_valid=0 or w != owner_idx):
  - owner_idx <= w, owner_valid <= 1.
  - credits <= max(weight[w],1) - 1, so a weight of 0 behaves as 1.
- If w is the existing owner: credits <= credits - 1, saturating at 0.
- lock <= ~request_last[w].
- If request_last[w]=1 and the post-update credits are 0: owner_valid <= 0.

Other cycles:
- Cycles with ena=0 or no grant: all state holds.
- Owner with credits>0 drops its request while lock=0: it forfeits. Round-robin picks the winner from base, which already points past the owner. The new winner replaces the owner.

Boundary conditions:
- Wrap-around: winner NUM_CLIENTS-1 sets base to 1.
- Single requester: it wins every cycle it requests.
- Lock ignores credits: a packet longer than its weight continues to completion. Credits stay at 0 during the overrun, and ownership ends on the last beat.
- Reset mid-packet clears lock immediately; the next cycle arbitrates fresh from client 0.

Test Plan:
1. Weights all 1, request=1111, last=1111, ena=1 held -> grantIdx sequence 0,1,2,3,0; grant is one-hot each cycle.
2. Weights {client0=3, others=1}, all request, last=1 -> grantIdx sequence 0,0,0,1,2,3,0,0,0.
3. Client1 sends a 4-beat packet (last=0,0,0,1) while client2 also requests, weight1=1 -> grantIdx sequence 1,1,1,1,2; locked=1 during beats 2-4.
4. While locked to client1, client1 deasserts request for 2 cycles with client3 requesting -> grant=0 for those 2 cycles, then client1 resumes and completes.
5. ena=0 for 3 cycles with request=1111 -> grant=0 and state unchanged; once ena returns to 1, the same winner as before the stall is granted.
6. reset asserted mid-lock on client2 -> locked=0 next cycle; with request=1111 the first grant after reset is client0.
